gateway_recv_filter: RTL and testbench

- Ingress packet filter of the vFIU receive path. It consumes AXI4-Stream packets tagged with a 14-bit route and checks each packet's sender_id against the host-programmed routing capability.
- Valid packets are forwarded whole to the vIO Switch port. Invalid packets are consumed and discarded whole.
- Per-packet decision, a registered output stage, and drop/accept statistics for host readback.

---
 rtl/gateway_pkg.sv | 24 ++
 rtl/axis_reg_stage.sv | 42 ++++
 rtl/gateway_recv_filter.sv | 128 ++++++++++++
 tb/tb_gateway_recv_filter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gateway_pkg.sv
// Shared route definitions for the vFIU gateway receive and send paths.
package gateway_pkg;

    localparam int unsigned ROUTE_W    = 14;
    localparam int unsigned SENDER_LSB = 6;
    localparam int unsigned SENDER_W   = 4;

    typedef enum logic [1:0] {
        HEAD = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } state_t;

    function automatic logic [SENDER_W-1:0] route_sender(input logic [ROUTE_W-1:0] route);
        return route[SENDER_LSB +: SENDER_W];
    endfunction

    // Zero on either side acts as a wildcard.
    function automatic logic sender_allowed(input logic [SENDER_W-1:0] sender,
                                            input logic [SENDER_W-1:0] allowed);
        return (sender == allowed) || (allowed == '0) || (sender == '0);
    endfunction

endpackage

// File: rtl/axis_reg_stage.sv
// One-entry AXI-Stream register slice carrying data/keep/last/user at full throughput.
module axis_reg_stage #(
    parameter int unsigned DATA_W = 512,
    parameter int unsigned USER_W = 14
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [DATA_W/8-1:0] in_keep,
    input  logic                in_last,
    input  logic [USER_W-1:0]   in_user,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [DATA_W-1:0]   out_data,
    output logic [DATA_W/8-1:0] out_keep,
    output logic                out_last,
    output logic [USER_W-1:0]   out_user,
    output logic                out_valid,
    input  logic                out_ready
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            out_user  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
            out_keep  <= in_keep;
            out_last  <= in_last;
            out_user  <= in_user;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/gateway_recv_filter.sv
// vFIU ingress filter: forwards or discards whole packets by head-beat sender_id.
// Define ROUTE_CHECK_EN to enable sender validation; undefined, every packet is forwarded.
module gateway_recv_filter
    import gateway_pkg::*;
#(
    parameter int unsigned DATA_W = 512,
    parameter int unsigned CNT_W  = 32
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [ROUTE_W-1:0]  route_ctrl,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic [DATA_W/8-1:0] s_axis_tkeep,
    input  logic                s_axis_tlast,
    input  logic [ROUTE_W-1:0]  s_axis_tuser,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    output logic [DATA_W-1:0]   m_axis_tdata,
    output logic [DATA_W/8-1:0] m_axis_tkeep,
    output logic                m_axis_tlast,
    output logic [ROUTE_W-1:0]  m_axis_tuser,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    input  logic                clr_cnt,
    output logic [CNT_W-1:0]    pkt_cnt,
    output logic [CNT_W-1:0]    drop_cnt,
    output logic                route_err,
    output logic [SENDER_W-1:0] err_sender
);

    state_t               state, state_next;
    logic [SENDER_W-1:0]  allowed_reg;
    logic [SENDER_W-1:0]  sender;
    logic [ROUTE_W-1:0]   route_reg;
    logic [ROUTE_W-1:0]   fwd_user;
    logic                 route_ok;
    logic                 drop_beat;
    logic                 fwd_valid;
    logic                 stage_ready;
    logic                 accept;
    logic                 head_fwd;
    logic                 head_drop;
    logic                 unused_ctrl;

    assign sender = route_sender(s_axis_tuser);

`ifdef ROUTE_CHECK_EN
    assign route_ok    = sender_allowed(sender, allowed_reg);
    assign unused_ctrl = ^{route_ctrl[ROUTE_W-1:SENDER_LSB+SENDER_W],
                           route_ctrl[SENDER_LSB-1:0]};
`else
    assign route_ok    = 1'b1;
    assign unused_ctrl = ^{route_ctrl[ROUTE_W-1:SENDER_LSB+SENDER_W],
                           route_ctrl[SENDER_LSB-1:0], allowed_reg};
`endif

    // Discarded beats bypass the output stage, so they never wait on m_axis_tready.
    assign drop_beat     = (state == DROP) || ((state == HEAD) && !route_ok);
    assign fwd_valid     = s_axis_tvalid && !drop_beat;
    assign s_axis_tready = aresetn && (drop_beat || stage_ready);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign head_fwd      = accept && (state == HEAD) && route_ok;
    assign head_drop     = accept && (state == HEAD) && !route_ok;
    assign fwd_user      = (state == HEAD) ? s_axis_tuser : route_reg;

    always_comb begin
        state_next = state;
        if (accept) begin
            unique case (state)
                HEAD:    if (!s_axis_tlast) state_next = route_ok ? PASS : DROP;
                PASS:    if (s_axis_tlast) state_next = HEAD;
                DROP:    if (s_axis_tlast) state_next = HEAD;
                default: state_next = HEAD;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) state <= HEAD;
        else          state <= state_next;
    end

    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cnt,
                                                  input logic inc, input logic clr);
        if (clr)                  return CNT_W'(inc);
        if (inc && (cnt != '1))   return cnt + CNT_W'(1);
        return cnt;
    endfunction

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            allowed_reg <= '0;
            route_reg   <= '0;
            pkt_cnt     <= '0;
            drop_cnt    <= '0;
            route_err   <= 1'b0;
            err_sender  <= '0;
        end else begin
            allowed_reg <= route_ctrl[SENDER_LSB +: SENDER_W];
            if (head_fwd) route_reg <= s_axis_tuser;
            pkt_cnt     <= cnt_next(pkt_cnt, head_fwd, clr_cnt);
            drop_cnt    <= cnt_next(drop_cnt, head_drop, clr_cnt);
            route_err   <= head_drop;
            if (head_drop) err_sender <= sender;
        end
    end

    axis_reg_stage #(
        .DATA_W (DATA_W),
        .USER_W (ROUTE_W)
    ) u_out_stage (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_data   (s_axis_tdata),
        .in_keep   (s_axis_tkeep),
        .in_last   (s_axis_tlast),
        .in_user   (fwd_user),
        .in_valid  (fwd_valid),
        .in_ready  (stage_ready),
        .out_data  (m_axis_tdata),
        .out_keep  (m_axis_tkeep),
        .out_last  (m_axis_tlast),
        .out_user  (m_axis_tuser),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready)
    );

endmodule

// File: tb/tb_gateway_recv_filter.sv
// Self-checking bench for gateway_recv_filter: vector table plus scoreboarded sequences.
module tb_gateway_recv_filter;

    localparam int DW = 64;
    localparam int KW = DW / 8;
    localparam int RW = 14;
`ifdef ROUTE_CHECK_EN
    localparam bit CHECK = 1'b1;
`else
    localparam bit CHECK = 1'b0;
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic [RW-1:0] user;
    } beat_t;

    typedef struct {
        logic [3:0] allowed;
        logic [3:0] sender;
        int         nb;
        bit         fwd;
        bit         rdy;
    } vec_t;

    logic          aclk;
    logic          aresetn;
    logic [RW-1:0] route_ctrl;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tlast;
    logic [RW-1:0] s_axis_tuser;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic [RW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          clr_cnt;
    logic [31:0]   pkt_cnt;
    logic [31:0]   drop_cnt;
    logic          route_err;
    logic [3:0]    err_sender;

    logic          s2_tready;
    logic [DW-1:0] s2_tdata;
    logic [KW-1:0] s2_tkeep;
    logic          s2_tlast;
    logic [RW-1:0] s2_tuser;
    logic          s2_tvalid;
    logic [2:0]    s2_pkt_cnt;
    logic [2:0]    s2_drop_cnt;
    logic          s2_route_err;
    logic [3:0]    s2_err_sender;

    int         checks = 0;
    int         errors = 0;
    beat_t      sb[$];
    int         exp_pkt = 0, exp_drop = 0, exp_sat = 0, exp_rerr = 0, rerr_seen = 0;
    logic [3:0] exp_es = '0;
    bit         rand_ready = 1'b0;
    bit         fixed_ready = 1'b1;
    beat_t      mon_cur, prev_beat;
    bit         prev_stall = 1'b0;
    vec_t       vecs[8];

    gateway_recv_filter #(.DATA_W(DW), .CNT_W(32)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .route_ctrl    (route_ctrl),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .clr_cnt       (clr_cnt),
        .pkt_cnt       (pkt_cnt),
        .drop_cnt      (drop_cnt),
        .route_err     (route_err),
        .err_sender    (err_sender)
    );

    // Narrow-counter copy fed the same traffic, used to observe saturation.
    gateway_recv_filter #(.DATA_W(DW), .CNT_W(3)) dut_sat (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .route_ctrl    (route_ctrl),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s2_tready),
        .m_axis_tdata  (s2_tdata),
        .m_axis_tkeep  (s2_tkeep),
        .m_axis_tlast  (s2_tlast),
        .m_axis_tuser  (s2_tuser),
        .m_axis_tvalid (s2_tvalid),
        .m_axis_tready (m_axis_tready),
        .clr_cnt       (clr_cnt),
        .pkt_cnt       (s2_pkt_cnt),
        .drop_cnt      (s2_drop_cnt),
        .route_err     (s2_route_err),
        .err_sender    (s2_err_sender)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        #1;
        m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : fixed_ready;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_ok(input logic [3:0] s, input logic [3:0] a);
        return !CHECK || (s == a) || (a == 4'd0) || (s == 4'd0);
    endfunction

    // Scoreboard consumer and AXI hold-stability checker.
    always @(negedge aclk) begin
        if (aresetn === 1'b1) begin
            mon_cur = {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
            if (prev_stall) check("stall_hold", {m_axis_tvalid, mon_cur}, {1'b1, prev_beat});
            if (m_axis_tvalid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected none at %0t", mon_cur, $time);
                end else if (m_axis_tready) begin
                    check("out_beat", mon_cur, sb.pop_front());
                end
            end
            prev_stall = (m_axis_tvalid === 1'b1) && !m_axis_tready;
            prev_beat  = mon_cur;
            if (route_err === 1'b1) rerr_seen++;
        end
    end

    task automatic send_pkt(input logic [3:0] sender, input int nb, input bit fwd,
                            input bit clr_head, input int chg_beat, input logic [3:0] chg_val);
        logic [RW-1:0] head_user;
        beat_t         b;
        bit            acc;
        int            guard;
        head_user      = RW'($urandom);
        head_user[9:6] = sender;
        for (int i = 0; i < nb; i++) begin
            if (i == chg_beat) route_ctrl[9:6] = chg_val;
            s_axis_tdata  = {$urandom, $urandom};
            s_axis_tkeep  = KW'($urandom);
            s_axis_tlast  = (i == nb - 1);
            s_axis_tuser  = (i == 0) ? head_user : RW'($urandom);
            s_axis_tvalid = 1'b1;
            clr_cnt       = clr_head && (i == 0);
            acc   = 1'b0;
            guard = 0;
            while (!acc && guard < 200) begin
                @(negedge aclk);
                acc = s_axis_tready;
                if (acc) begin
                    b = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, head_user};
                    if (fwd) sb.push_back(b);
                    if (i == 0) begin
                        if (clr_cnt) begin
                            exp_pkt  = int'(fwd);
                            exp_drop = int'(!fwd);
                            exp_sat  = int'(fwd);
                        end else if (fwd) begin
                            exp_pkt++;
                            if (exp_sat < 7) exp_sat++;
                        end else begin
                            exp_drop++;
                        end
                        if (!fwd) begin
                            exp_rerr++;
                            exp_es = sender;
                        end
                    end
                end else if (clr_cnt) begin
                    exp_pkt  = 0;
                    exp_drop = 0;
                    exp_sat  = 0;
                end
                @(posedge aclk);
                #1;
                guard++;
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL ingress_timeout: got no s_axis_tready expected accept of beat %0d", i);
            end
        end
        s_axis_tvalid = 1'b0;
        clr_cnt       = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 500) begin
            @(posedge aclk);
            #1;
            g++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", sb.size());
        end
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_pkt_cnt"}, pkt_cnt, exp_pkt);
        check({tag, "_drop_cnt"}, drop_cnt, exp_drop);
        check({tag, "_err_sender"}, err_sender, exp_es);
        check({tag, "_route_err_pulses"}, rerr_seen, exp_rerr);
    endtask

    task automatic set_allowed(input logic [3:0] a);
        route_ctrl      = RW'($urandom);
        route_ctrl[9:6] = a;
        repeat (2) @(posedge aclk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ef;
        vecs[0] = '{4'd3,  4'd3,  4, 1'b1, 1'b1};
        vecs[1] = '{4'd3,  4'd5,  3, 1'b0, 1'b0};
        vecs[2] = '{4'd0,  4'd9,  2, 1'b1, 1'b1};
        vecs[3] = '{4'd7,  4'd0,  1, 1'b1, 1'b1};
        vecs[4] = '{4'd4,  4'd5,  2, 1'b0, 1'b1};
        vecs[5] = '{4'd5,  4'd6,  1, 1'b0, 1'b0};
        vecs[6] = '{4'd2,  4'd1,  5, 1'b0, 1'b1};
        vecs[7] = '{4'd15, 4'd15, 3, 1'b1, 1'b1};

        aresetn       = 1'b0;
        route_ctrl    = 14'h3fff;
        s_axis_tdata  = '1;
        s_axis_tkeep  = '1;
        s_axis_tlast  = 1'b1;
        s_axis_tuser  = 14'h0240;
        s_axis_tvalid = 1'b1;
        clr_cnt       = 1'b0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_s_tready", s_axis_tready, 0);
        check("rst_m_tvalid", m_axis_tvalid, 0);
        check("rst_m_payload", {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser}, 0);
        check("rst_pkt_cnt", pkt_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_route_err", route_err, 0);
        check("rst_err_sender", err_sender, 0);
        s_axis_tvalid = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1;

        for (int v = 0; v < 8; v++) begin
            ef = vecs[v].fwd || !CHECK;
            set_allowed(vecs[v].allowed);
            fixed_ready = ef ? 1'b1 : vecs[v].rdy;
            repeat (2) @(posedge aclk);
            #1;
            send_pkt(vecs[v].sender, vecs[v].nb, ef, 1'b0, -1, 4'd0);
            fixed_ready = 1'b1;
            drain();
            check_counters($sformatf("vec%0d", v));
        end

        // Back-to-back single-beat packets, mixing forward and drop decisions.
        set_allowed(4'd7);
        send_pkt(4'd7, 1, 1'b1, 1'b0, -1, 4'd0);
        send_pkt(4'd0, 1, 1'b1, 1'b0, -1, 4'd0);
        send_pkt(4'd5, 1, model_ok(4'd5, 4'd7), 1'b0, -1, 4'd0);
        send_pkt(4'd7, 2, 1'b1, 1'b0, -1, 4'd0);
        drain();
        check_counters("b2b");

        // Routing change mid-packet only affects the following packet.
        set_allowed(4'd3);
        send_pkt(4'd3, 5, 1'b1, 1'b0, 1, 4'd4);
        send_pkt(4'd3, 2, model_ok(4'd3, 4'd4), 1'b0, -1, 4'd0);
        drain();
        check_counters("route_chg");

        // Random egress back-pressure.
        set_allowed(4'd6);
        rand_ready = 1'b1;
        for (int p = 0; p < 100; p++) begin
            logic [3:0] s;
            s = 4'($urandom_range(0, 15));
            send_pkt(s, $urandom_range(1, 4), model_ok(s, 4'd6), 1'b0, -1, 4'd0);
        end
        rand_ready = 1'b0;
        drain();
        check_counters("random");

        // Clear alone, then clear coinciding with a head accept.
        clr_cnt = 1'b1;
        @(posedge aclk);
        #1;
        clr_cnt  = 1'b0;
        exp_pkt  = 0;
        exp_drop = 0;
        exp_sat  = 0;
        check("clr_only_pkt", pkt_cnt, exp_pkt);
        check("clr_only_drop", drop_cnt, exp_drop);
        set_allowed(4'd4);
        send_pkt(4'd4, 2, 1'b1, 1'b1, -1, 4'd0);
        drain();
        check("clr_inc_pkt", pkt_cnt, exp_pkt);
        check("clr_inc_drop", drop_cnt, exp_drop);

        // Saturation of the narrow-counter instance.
        for (int p = 0; p < 9; p++) send_pkt(4'd4, 1, 1'b1, 1'b0, -1, 4'd0);
        drain();
        check("sat_pkt_cnt", s2_pkt_cnt, exp_sat);
        check("wide_pkt_cnt", pkt_cnt, exp_pkt);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
